wm_cycle_controller: RTL
========================

Name: wm_cycle_controller

Overview:
- Sequences one washing cycle from a stored preset in the four-slot washing-machine preset bank.
- On `start`, it issues a one-cycle bank read for the selected slot and captures the 5-bit fill (cloth), wash, rinse and spin durations.
- It then steps FILL -> WASH -> DRAIN -> RINSE -> SPIN -> DONE and drives the valves, motor and door lock.
- Sits between the front panel (start/pause/abort/mode) and the preset bank / actuator drivers.

Parameters:
- TICK_DIV, 4: clk cycles per time tick; legal range 1..255.
- DRAIN_TICKS, 2: fixed DRAIN phase length in ticks; legal range 1..31.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a cycle; sampled only in IDLE.
- mode  input  2  preset slot to run; sampled with start.
- pause  input  1  level; freezes timing while high.
- abort  input  1  level; terminates the cycle via DRAIN.
- cfg_read  output  1  preset bank read strobe; maps to bank s0=1.
- cfg_sel  output  2  preset bank slot select; maps to s1,s2.
- cfg_wash, cfg_rinse, cfg_spin, cfg_cloth  input  5 each  preset bank outputs.
- valve_in  output  1  water fill valve.
- drain_valve  output  1  drain pump/valve.
- motor_speed  output  2  0=off, 1=agitate, 3=spin.
- door_lock  output  1  door lock.
- busy  output  1  high in every state except IDLE.
- phase  output  4  state encoding.
- remaining  output  5  ticks left in the current timed phase.
- done  output  1  one-cycle pulse at cycle end.
- aborted  output  1  one-cycle pulse with done when the cycle ended by abort.

Behaviour:
- Reset (rst high at clk edge):
  - Wins over every other input.
  - Next state IDLE; every output 0.
  - Captured durations, tick counter and remaining all cleared.
  - Mid-cycle reset drops all actuators the same cycle and does not produce a done pulse.
- State encodings (phase): IDLE=0, FETCH=1, CAPTURE=2, FILL=3, WASH=4, DRAIN=5, RINSE=6, SPIN=7, DONE=8.
- IDLE:
  - start=1 -> FETCH; mode is latched.
  - start held high in IDLE retriggers the next cycle.
  - start is ignored in all other states.
- FETCH (one cycle): cfg_read=1, cfg_sel=latched mode; then CAPTURE.
- CAPTURE (one cycle):
  - Registers cfg_* (bank output is valid the cycle after the strobe).
  - Goes to FILL with remaining = captured cloth value.
- Timed phases (FILL, WASH, DRAIN, RINSE, SPIN):
  - Entry loads remaining with the phase duration and sets the tick counter to 0. Durations: cloth, wash, DRAIN_TICKS, rinse, spin.
  - The tick counter runs 0..TICK_DIV-1; a tick occurs when it is at TICK_DIV-1 and not paused.
  - Each tick decrements remaining.
  - The tick that takes remaining from 1 to 0 advances to the next phase.
  - A phase of N>0 therefore lasts exactly N*TICK_DIV cycles.
  - A duration of 0 occupies exactly one cycle with remaining=0, then advances.
- Phase order: FILL -> WASH -> DRAIN -> RINSE -> SPIN -> DONE.
- DONE (one cycle): done=1 (aborted=1 if the abort flag is set); then IDLE, flag cleared.
- Outputs are a registered decode of the state:
  - FILL: valve_in=1.
  - WASH and RINSE: motor_speed=1.
  - DRAIN: drain_valve=1.
  - SPIN: drain_valve=1, motor_speed=3.
  - door_lock=1 in FILL through SPIN inclusive.
  - remaining=0 outside timed phases.
- Pause (timed phases only):
  - Tick counter and remaining hold.
  - valve_in, drain_valve and motor_speed are forced to 0; door_lock stays 1.
  - Release resumes from the held count with no lost or extra cycles.
  - pause is ignored in IDLE, FETCH, CAPTURE and DONE.
- Abort (priority over pause):
  - In FETCH or CAPTURE -> IDLE; no done pulse.
  - In FILL, WASH, RINSE or SPIN -> DRAIN with remaining=DRAIN_TICKS; abort flag set.
  - In DRAIN -> flag set, drain continues uninterrupted.
  - After DRAIN the machine goes straight to DONE, skipping RINSE and SPIN.
  - Abort while paused in DRAIN still waits for pause release to count.
  - abort held high has no further effect once the flag is set.
- All outputs are registered; there is no combinational path from any input to any output.

Test Plan:
- Normal run: reset, preset slot 2 = {cloth=2, wash=3, rinse=2, spin=1}, TICK_DIV=4, start with mode=2.
  - cfg_read=1 with cfg_sel=2 for exactly 1 cycle.
  - Phase lengths: FILL 8, WASH 12, DRAIN 8, RINSE 8, SPIN 4 cycles.
  - done pulses 42 cycles after FETCH entry; aborted=0; busy falls the same cycle state returns to IDLE.
- Zero durations: preset {cloth=0, wash=5, rinse=0, spin=0}.
  - FILL, RINSE and SPIN each last 1 cycle with remaining=0.
  - WASH lasts 20 cycles; DRAIN lasts 8 cycles.
- Pause mid-WASH: pause high for 10 cycles at remaining=2.
  - remaining and phase are frozen; motor_speed=0; door_lock=1.
  - After release, WASH ends exactly 10 cycles later than in the unpaused run.
- Abort in WASH: abort pulse at WASH remaining=3.
  - Next state is DRAIN with remaining=2 for 8 cycles, then DONE.
  - done=1 and aborted=1 together; RINSE and SPIN are never entered.
- Abort in FETCH: abort together with the cycle after start.
  - Returns to IDLE; no done pulse; all actuators stay 0.
- Reset mid-SPIN, and start while busy:
  - rst in SPIN -> all outputs 0 the next cycle, phase=0, no done.
  - start=1 during RINSE is ignored; remaining is unchanged.

Source files
------------

// File: rtl/wm_cycle_controller.sv
// Washing-machine cycle sequencer: fetches a preset from the bank, then steps
// FILL/WASH/DRAIN/RINSE/SPIN with tick-based timing, pause and abort handling.
module wm_cycle_controller #(
  parameter int TICK_DIV    = 4,
  parameter int DRAIN_TICKS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic       pause,
  input  logic       abort,
  output logic       cfg_read,
  output logic [1:0] cfg_sel,
  input  logic [4:0] cfg_wash,
  input  logic [4:0] cfg_rinse,
  input  logic [4:0] cfg_spin,
  input  logic [4:0] cfg_cloth,
  output logic       valve_in,
  output logic       drain_valve,
  output logic [1:0] motor_speed,
  output logic       door_lock,
  output logic       busy,
  output logic [3:0] phase,
  output logic [4:0] remaining,
  output logic       done,
  output logic       aborted
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_CAPTURE = 4'd2,
    S_FILL    = 4'd3,
    S_WASH    = 4'd4,
    S_DRAIN   = 4'd5,
    S_RINSE   = 4'd6,
    S_SPIN    = 4'd7,
    S_DONE    = 4'd8
  } state_t;

  localparam logic [7:0] TICK_LAST = 8'(TICK_DIV - 1);
  localparam logic [4:0] DRAIN_LEN = 5'(DRAIN_TICKS);

  state_t     state_q, state_n;
  logic [7:0] tick_q, tick_n;
  logic [4:0] rem_q, rem_n;
  logic [4:0] wash_q, rinse_q, spin_q;
  logic [1:0] mode_q, mode_n;
  logic       flag_q, flag_n;
  logic       capture_en;
  logic       advance;

  // Next-output decode, registered below so outputs line up with state_q.
  logic       valve_n, drain_n, door_n, busy_n, done_n, aborted_n, read_n;
  logic [1:0] motor_n, sel_n;
  logic       timed_n, hold_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      rem_q   <= '0;
      wash_q  <= '0;
      rinse_q <= '0;
      spin_q  <= '0;
      mode_q  <= '0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      tick_q  <= tick_n;
      rem_q   <= rem_n;
      mode_q  <= mode_n;
      flag_q  <= flag_n;
      if (capture_en) begin
        wash_q  <= cfg_wash;
        rinse_q <= cfg_rinse;
        spin_q  <= cfg_spin;
      end
    end
  end

  always_comb begin
    state_n    = state_q;
    tick_n     = tick_q;
    rem_n      = rem_q;
    mode_n     = mode_q;
    flag_n     = flag_q;
    capture_en = 1'b0;
    advance    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_n = S_FETCH;
          mode_n  = mode;
          flag_n  = 1'b0;
        end
      end
      S_FETCH: state_n = abort ? S_IDLE : S_CAPTURE;
      S_CAPTURE: begin
        if (abort) begin
          state_n = S_IDLE;
        end else begin
          state_n    = S_FILL;
          rem_n      = cfg_cloth;
          tick_n     = '0;
          capture_en = 1'b1;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
        flag_n  = 1'b0;
        rem_n   = '0;
      end
      default: begin
        // Timed phases. Abort outside DRAIN restarts a fresh DRAIN at once.
        if (abort && state_q != S_DRAIN) begin
          state_n = S_DRAIN;
          rem_n   = DRAIN_LEN;
          tick_n  = '0;
          flag_n  = 1'b1;
        end else begin
          if (abort) flag_n = 1'b1;
          if (rem_q == 5'd0) begin
            advance = 1'b1;
          end else if (!pause) begin
            if (tick_q == TICK_LAST) begin
              tick_n = '0;
              rem_n  = 5'(rem_q - 5'd1);
              if (rem_q == 5'd1) advance = 1'b1;
            end else begin
              tick_n = 8'(tick_q + 8'd1);
            end
          end
          if (advance) begin
            tick_n = '0;
            case (state_q)
              S_FILL: begin
                state_n = S_WASH;
                rem_n   = wash_q;
              end
              S_WASH: begin
                state_n = S_DRAIN;
                rem_n   = DRAIN_LEN;
              end
              S_DRAIN: begin
                state_n = flag_n ? S_DONE : S_RINSE;
                rem_n   = flag_n ? 5'd0 : rinse_q;
              end
              S_RINSE: begin
                state_n = S_SPIN;
                rem_n   = spin_q;
              end
              default: begin
                state_n = S_DONE;
                rem_n   = '0;
              end
            endcase
          end
        end
      end
    endcase
  end

  always_comb begin
    timed_n   = (state_n >= S_FILL) && (state_n <= S_SPIN);
    hold_n    = pause && timed_n;
    valve_n   = (state_n == S_FILL) && !hold_n;
    drain_n   = ((state_n == S_DRAIN) || (state_n == S_SPIN)) && !hold_n;
    motor_n   = 2'd0;
    if (!hold_n) begin
      if (state_n == S_WASH || state_n == S_RINSE) motor_n = 2'd1;
      else if (state_n == S_SPIN)                  motor_n = 2'd3;
    end
    door_n    = timed_n;
    busy_n    = (state_n != S_IDLE);
    done_n    = (state_n == S_DONE);
    aborted_n = (state_n == S_DONE) && flag_n;
    read_n    = (state_n == S_FETCH);
    sel_n     = (state_n == S_FETCH) ? mode_n : 2'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valve_in    <= 1'b0;
      drain_valve <= 1'b0;
      motor_speed <= 2'd0;
      door_lock   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
      cfg_read    <= 1'b0;
      cfg_sel     <= 2'd0;
    end else begin
      valve_in    <= valve_n;
      drain_valve <= drain_n;
      motor_speed <= motor_n;
      door_lock   <= door_n;
      busy        <= busy_n;
      done        <= done_n;
      aborted     <= aborted_n;
      cfg_read    <= read_n;
      cfg_sel     <= sel_n;
    end
  end

  // phase doubles as the debug view of the FSM state.
  assign phase     = state_q;
  assign remaining = rem_q;

endmodule
